// File: rtl/mtr_drv_pwm.sv
// H-bridge PWM driver for the two wheel motors of the balance controller.
// Period-synchronous duty updates with a dead interval on every direction reversal.

module mtr_drv_side #(
    parameter int unsigned PWM_W        = 11,
    parameter int unsigned DEAD_PERIODS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] cnt,
    input  logic             smp,
    input  logic [PWM_W-1:0] spd,
    input  logic             rev,
    output logic             pwm1,
    output logic             pwm2
);
    localparam int unsigned DW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS + 1) : 1;

    typedef enum logic {RUN, DEAD} state_t;

    state_t           state;
    logic             dir;
    logic [PWM_W-1:0] duty;
    logic [DW-1:0]    dead_cnt;

    // Sample point is cnt==max, so the pwm term is always 0 on the edge where
    // state/dir change: the legs can never overlap across a reversal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            dir      <= 1'b0;
            duty     <= '0;
            dead_cnt <= '0;
            pwm1     <= 1'b0;
            pwm2     <= 1'b0;
        end else begin
            pwm1 <= (state == RUN) && !dir && (cnt < duty);
            pwm2 <= (state == RUN) &&  dir && (cnt < duty);
            if (smp) begin
                case (state)
                    RUN: begin
                        if (rev != dir) begin
                            state    <= DEAD;
                            dead_cnt <= '0;
                        end else begin
                            duty <= spd;
                        end
                    end
                    DEAD: begin
                        // Last dead boundary: take the latest sample, whichever direction it names.
                        if (dead_cnt == DW'(DEAD_PERIODS - 1)) begin
                            state <= RUN;
                            dir   <= rev;
                            duty  <= spd;
                        end else begin
                            dead_cnt <= dead_cnt + DW'(1);
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end
endmodule

module mtr_drv_pwm #(
    parameter int unsigned PWM_W        = 11,
    parameter int unsigned DEAD_PERIODS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] lft_spd,
    input  logic             lft_rev,
    input  logic [PWM_W-1:0] rght_spd,
    input  logic             rght_rev,
    output logic             PWM1_lft,
    output logic             PWM2_lft,
    output logic             PWM1_rght,
    output logic             PWM2_rght,
    output logic             prd_strt
);
    localparam logic [PWM_W-1:0] CNT_MAX = '1;

    logic [PWM_W-1:0] cnt;
    logic             smp;

    assign smp = (cnt == CNT_MAX);

    // Free-running period counter and period-start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            prd_strt <= 1'b0;
        end else begin
            cnt      <= cnt + PWM_W'(1);
            prd_strt <= smp;
        end
    end

    mtr_drv_side #(.PWM_W(PWM_W), .DEAD_PERIODS(DEAD_PERIODS)) u_lft (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .smp   (smp),
        .spd   (lft_spd),
        .rev   (lft_rev),
        .pwm1  (PWM1_lft),
        .pwm2  (PWM2_lft)
    );

    mtr_drv_side #(.PWM_W(PWM_W), .DEAD_PERIODS(DEAD_PERIODS)) u_rght (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .smp   (smp),
        .spd   (rght_spd),
        .rev   (rght_rev),
        .pwm1  (PWM1_rght),
        .pwm2  (PWM2_rght)
    );
endmodule

// File: tb/tb_mtr_drv_pwm.sv
// Randomized + directed bench for mtr_drv_pwm against a per-period behavioural model.

module tb_mtr_drv_pwm;
    localparam int PWM_W = 11;
    localparam int N     = 2 ** PWM_W;
    localparam int DEADP = 1;

    logic             clk;
    logic             rst_n;
    logic [PWM_W-1:0] lft_spd, rght_spd;
    logic             lft_rev, rght_rev;
    logic             PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght, prd_strt;

    mtr_drv_pwm #(.PWM_W(PWM_W), .DEAD_PERIODS(DEADP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_spd   (lft_spd),
        .lft_rev   (lft_rev),
        .rght_spd  (rght_spd),
        .rght_rev  (rght_rev),
        .PWM1_lft  (PWM1_lft),
        .PWM2_lft  (PWM2_lft),
        .PWM1_rght (PWM1_rght),
        .PWM2_rght (PWM2_rght),
        .prd_strt  (prd_strt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: position in period plus, per side, the drive plan of the current period.
    int mcnt;
    bit mwrap;
    bit m_run[2];
    bit m_dir[2];
    int m_duty[2];
    int m_dead[2];

    int h1l, h2l, h1r, h2r, hps;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mcnt  = 0;
        mwrap = 0;
        for (int s = 0; s < 2; s++) begin
            m_run[s]  = 1;
            m_dir[s]  = 0;
            m_duty[s] = 0;
            m_dead[s] = 0;
        end
    endtask

    // Decide what a side drives in the coming period from the value it sees at the boundary.
    task automatic boundary(input int s, input bit sdir, input int sduty);
        if (m_run[s]) begin
            if (sdir != m_dir[s]) begin
                m_run[s]  = 0;
                m_dead[s] = DEADP;
            end else begin
                m_duty[s] = sduty;
            end
        end else begin
            m_dead[s]--;
            if (m_dead[s] == 0) begin
                m_run[s]  = 1;
                m_dir[s]  = sdir;
                m_duty[s] = sduty;
            end
        end
    endtask

    task automatic advance();
        if (mcnt == N - 1) begin
            boundary(0, lft_rev, int'(lft_spd));
            boundary(1, rght_rev, int'(rght_spd));
            mwrap = 1;
            mcnt  = 0;
        end else begin
            mcnt++;
        end
    endtask

    // During period position c a leg is high iff 1 <= c <= duty (registered compare).
    task automatic compare();
        bit on[2];
        for (int s = 0; s < 2; s++)
            on[s] = m_run[s] && (mcnt >= 1) && (mcnt <= m_duty[s]);
        chk("pwm1_lft",  int'(PWM1_lft),  int'(on[0] && !m_dir[0]));
        chk("pwm2_lft",  int'(PWM2_lft),  int'(on[0] &&  m_dir[0]));
        chk("pwm1_rght", int'(PWM1_rght), int'(on[1] && !m_dir[1]));
        chk("pwm2_rght", int'(PWM2_rght), int'(on[1] &&  m_dir[1]));
        chk("prd_strt",  int'(prd_strt),  int'(mcnt == 0 && mwrap));
        chk("overlap_lft",  int'(PWM1_lft & PWM2_lft), 0);
        chk("overlap_rght", int'(PWM1_rght & PWM2_rght), 0);
        h1l += int'(PWM1_lft);
        h2l += int'(PWM2_lft);
        h1r += int'(PWM1_rght);
        h2r += int'(PWM2_rght);
        hps += int'(prd_strt);
    endtask

    task automatic step();
        advance();
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr();
        h1l = 0; h2l = 0; h1r = 0; h2r = 0; hps = 0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        compare();
    endtask

    task automatic rnd_spd(output logic [PWM_W-1:0] v);
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            default: v = PWM_W'($urandom_range(0, N - 1));
        endcase
    endtask

    initial begin
        rst_n    = 1'b0;
        lft_spd  = PWM_W'(1500);
        rght_spd = PWM_W'(1500);
        lft_rev  = 1'b0;
        rght_rev = 1'b0;
        clr();
        release_reset();

        // Reset release: first period all low, then 1500 high; async reset mid-period.
        clr(); run(N);
        chk("first_prd_lft", h1l + h2l, 0);
        chk("first_prd_rght", h1r + h2r, 0);
        clr(); run(N);
        chk("duty1500_lft", h1l, 1500);
        run(700);
        chk("pre_reset_high", int'(PWM1_lft), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_outs", int'({PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght, prd_strt}), 0);
        release_reset();

        // Half duty left, zero then full-scale right.
        lft_spd = PWM_W'(1024);
        rght_spd = '0;
        clr(); run(N);
        chk("post_rst_prd", h1l + h1r, 0);
        rght_spd = '1;
        clr(); run(N);
        chk("duty1024_lft", h1l, 1024);
        chk("duty1024_pwm2", h2l, 0);
        chk("duty0_rght", h1r + h2r, 0);
        chk("prd_strt_count", hps, 1);
        clr(); run(N);
        chk("duty_max_rght", h1r, N - 1);
        chk("prd_strt_count2", hps, 1);

        // Mid-period duty change waits for the next period.
        lft_spd = PWM_W'(200);
        clr(); run(N);
        clr(); run(500);
        lft_spd = PWM_W'(900);
        run(N - 500);
        chk("duty200_hold", h1l, 200);
        clr(); run(N);
        chk("duty900_next", h1l, 900);

        // Reverse, then restore during dead period: one dead period, resume forward.
        lft_rev = 1'b1;
        clr(); run(N);
        chk("pre_rev_fwd", h1l, 900);
        clr(); run(1000);
        lft_rev = 1'b0;
        run(N - 1000);
        chk("dead_restore", h1l + h2l, 0);
        clr(); run(N);
        chk("resume_fwd", h1l, 900);
        chk("resume_fwd_pwm2", h2l, 0);

        // Full reversal at 600.
        lft_spd = PWM_W'(600);
        lft_rev = 1'b1;
        clr(); run(N);
        chk("rev_prev_prd", h1l, 900);
        clr(); run(N);
        chk("rev_dead", h1l + h2l, 0);
        chk("rev_dead_rght", h1r, N - 1);
        clr(); run(N);
        chk("rev_pwm2", h2l, 600);
        chk("rev_pwm1", h1l, 0);
        chk("rev_rght", h1r, N - 1);

        // Random inputs, changing at arbitrary cycles.
        for (int i = 0; i < 10 * N; i++) begin
            if ($urandom_range(0, 299) == 0) rnd_spd(lft_spd);
            if ($urandom_range(0, 299) == 0) rnd_spd(rght_spd);
            if ($urandom_range(0, 1499) == 0) lft_rev = ~lft_rev;
            if ($urandom_range(0, 1499) == 0) rght_rev = ~rght_rev;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
